// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs WORD_BYTES bytes (first byte in [7:0]) into a 32-bit word.
// A framing error or an inter-byte idle timeout drops the partial word so packing realigns.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORD_BYTES   = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic [31:0] o_word,
  output logic        o_valid,
  output logic        o_frame_err
);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW  = $clog2(TMO + 1);
  localparam int BCW = $clog2(WORD_BYTES);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e         state_q, state_d;
  logic           rx_meta_q, rx_s_q;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    word_q, word_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tmo_d      = tmo_q;
    case (state_q)
      S_IDLE: begin
        // Expiry is handled before the start check so a coincident start begins a fresh word.
        if (byte_cnt_q != '0) begin
          if (tmo_q == TMO_LAST) begin
            byte_cnt_d = '0;
            acc_d      = '0;
            tmo_d      = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        if (!rx_s_q) begin
          clk_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          tmo_d     = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            acc_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
            if (byte_cnt_q == LAST_BYTE) begin
              word_d     = acc_d;
              valid_d    = 1'b1;
              acc_d      = '0;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
            acc_d      = '0;
            state_d    = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_word      = word_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: expected words queued at send time, checked on o_valid.
module tb_uart_word_rx;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] o_word;
  logic        o_valid, o_frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_word = '0;
  logic        prev_valid = 1'b0;
  logic        skip_stab = 1'b1;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .TIMEOUT_BITS(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_word(o_word), .o_valid(o_valid), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: pops scoreboard on each valid, checks pulse shape and word stability.
  always @(negedge clk) begin
    if (o_valid || o_frame_err) chk("valid_ferr_excl", {31'b0, o_valid & o_frame_err}, 32'd0);
    if (o_frame_err) ferr_seen++;
    if (o_valid) begin
      chk("valid_width", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) chk("spurious_valid", {31'b0, o_valid}, 32'd0);
      else chk("word", o_word, exp_q.pop_front());
    end else if (!skip_stab && o_word !== prev_word) begin
      chk("word_stable", o_word, prev_word);
    end
    skip_stab  = rst;
    prev_word  = o_word;
    prev_valid = o_valid;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, gap);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_word", o_word, 32'd0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ferr", {31'b0, o_frame_err}, 32'd0);
    @(posedge clk); #1;
    drive_bit(1'b1);

    // 1: single word, 1-bit gaps
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678, 1);
    drain("t1_drain");
    chk("t1_ferr", ferr_seen, 32'd0);

    // 2: two words back to back, no gap
    exp_q.push_back(32'hDDCCBBAA);
    exp_q.push_back(32'h44332211);
    send_word(32'hDDCCBBAA, 0);
    send_word(32'h44332211, 0);
    drive_bit(1'b1);
    drain("t2_drain");

    // 3: framing error discards partial word
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b0, 2);
    chk("t3_ferr", ferr_seen, 32'd1);
    exp_q.push_back(32'hD4C3B2A1);
    send_word(32'hD4C3B2A1, 1);
    drain("t3_drain");

    // 4: short glitch is ignored
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("t4_state", {29'b0, dut.state_q}, 32'd0);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D, 1);
    drain("t4_drain");

    // 5: stale bytes dropped by idle timeout
    send_byte(8'h01, 1'b1, 25);
    send_byte(8'h02, 1'b1, 25);
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1);
    drain("t5_drain");

    // 6: reset in the middle of byte 3
    send_byte(8'h55, 1'b1, 1);
    send_byte(8'h66, 1'b1, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("t6_rst_word", o_word, 32'd0);
    chk("t6_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("t6_rst_ferr", {31'b0, o_frame_err}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("t6_word_held", o_word, 32'd0);
    exp_q.push_back(32'h04030201);
    send_word(32'h04030201, 1);
    drain("t6_drain");

    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("total_ferr", ferr_seen, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
